clkdiv_multi_ch: RTL and testbench
==================================

Name: clkdiv_multi_ch

Overview:
- Multi-channel programmable clock/tick generator; successor to the single-output dynamic sub-clock divider.
- Each channel divides CLK by a run-time half-period value written over a simple write port.
- Divisor changes are applied glitch-free at the channel's next toggle boundary.
- Serves peripheral timing (UART baud ticks, PWM/LED refresh, sample strobes); the table-driven Freq lookup is replaced by direct divisor programming done by firmware.

Parameters:
- NUM_CH, 4, number of independent output channels (1..16).
- CNT_W, 26, width of half-period value and per-channel counter.
- DEFAULT_HALF, 25000000, half-period loaded into every channel at reset (1 Hz from 50 MHz).
- CH_W, $clog2(NUM_CH) (min 1), width of channel index.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  NUM_CH  per-channel run enable.
- SYNC  in  1  single-cycle strobe that phase-aligns all channels.
- WR_EN  in  1  divisor write strobe.
- WR_CH  in  CH_W  target channel of write.
- WR_HALF  in  CNT_W  new half-period in CLK cycles; 0 = channel parked.
- OUTCLK  out  NUM_CH  divided clock levels, registered.
- TICK  out  NUM_CH  one-CLK pulse coincident with each OUTCLK rising edge, registered.
- PENDING  out  NUM_CH  channel has a written divisor not yet applied.

Behaviour:
- Reset (async assert, sync release): counters 0; active half = DEFAULT_HALF; shadow clear; OUTCLK, TICK, PENDING all 0.
- Per channel state: cnt[CNT_W], active_half[CNT_W], shadow_half[CNT_W], pending bit, out bit.
- Running (EN=1, active_half != 0): cnt increments each CLK. When cnt == active_half-1: cnt <= 0, out toggles (boundary), and a pending shadow is applied (active_half <= shadow_half, pending <= 0).
- Output period = 2*active_half CLK cycles, 50% duty. active_half=1 gives CLK/2.
- TICK=1 for exactly one cycle, the same cycle OUTCLK first reads 1 after a boundary; otherwise 0.
- Write: WR_EN=1 with WR_CH < NUM_CH: shadow_half <= WR_HALF, pending <= 1. WR_CH >= NUM_CH: ignored, no state change.
- Write on a boundary cycle of the same channel bypasses the shadow: WR_HALF becomes active at that boundary, pending stays 0.
- Back-to-back writes before a boundary: last write wins.
- Parked (active_half == 0) or disabled: a pending write is applied on the next cycle, not deferred.
- EN=0: cnt held at 0, out forced 0, TICK 0; pending values are applied immediately. EN 0->1: first boundary occurs active_half cycles later, so the first OUTCLK rise is at cycle active_half.
- active_half == 0 with EN=1: out held 0, cnt held 0, no TICK.
- SYNC=1: every channel's cnt <= 0, out <= 0, TICK <= 0, pending applied. SYNC overrides a boundary in the same cycle. A write in the SYNC cycle is applied immediately.
- Counter wrap: cnt never exceeds active_half-1. If a write lowers the divisor, the new value is applied only at the next boundary, so no long wrap-through occurs.
- Latency: WR_EN to PENDING=1 is one cycle. A channel's outputs depend only on its own state plus SYNC.

Decomposition:
- Package clkdiv_pkg: CNT_W default, DEFAULT_HALF, helper function half_from_hz(clk_hz, out_hz) = clk_hz/(2*out_hz) for firmware/testbench use.
- Sub-module clkdiv_channel (one instance per channel via generate). It holds cnt, active/shadow/pending, out and tick. The top level only decodes WR_CH to per-channel write strobes and fans out SYNC.

Test Plan:
- Reset release with EN=1, DEFAULT_HALF overridden to 4 → OUTCLK[0] period 8 cycles, TICK[0] every 8 cycles, first rise at cycle 4.
- Write ch1 half=3 while running half=5, mid-period → PENDING[1]=1 until boundary; the current half-period finishes at 5, then half-periods of 3. No runt pulse shorter than 3 cycles.
- Write ch2 half=0 then half=2 with EN[2]=1 → output parks at 0. The second write applies the next cycle; first rise 2 cycles later.
- SYNC pulsed with channels at half=2,3,5 in arbitrary phases → all OUTCLK=0 the next cycle; rises at +2, +3 and +5 cycles respectively.
- Write to WR_CH=NUM_CH (out of range) → no PENDING change; all channels' periods unchanged.
- Assert RST_N low mid-period with PENDING set → outputs and PENDING go to 0 immediately (asynchronous). After release, the channel runs at DEFAULT_HALF.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants and a firmware-side helper for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int          CNT_W_DEF        = 26;
    localparam int unsigned DEFAULT_HALF_DEF = 25_000_000;

    // Half-period in CLK cycles for a wanted output frequency (truncating).
    function automatic int unsigned half_from_hz(input longint unsigned clk_hz,
                                                 input longint unsigned out_hz);
        return 32'(clk_hz / (2 * out_hz));
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: 50% duty output of period 2*active_half, with a shadowed half-period write.
// Latency: write to pending is 1 cycle. Outputs are registered. There is no backpressure.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int          CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_half,
    output logic             out_clk,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             boundary;
    logic [CNT_W-1:0] next_half;

    assign boundary = (cnt_q == active_q - CNT_W'(1));

    always_comb begin
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        out_d     = out_q;
        tick_d    = 1'b0;
        next_half = pend_q ? shadow_q : active_q;
        if (sync) begin
            cnt_d    = '0;
            out_d    = 1'b0;
            pend_d   = 1'b0;
            active_d = wr_en ? wr_half : next_half;
        end else if (!en || active_q == '0) begin
            // Idle channel: drain any pending value now; a fresh write lands in the shadow first.
            cnt_d    = '0;
            out_d    = 1'b0;
            active_d = next_half;
            pend_d   = wr_en;
            if (wr_en) begin
                shadow_d = wr_half;
            end
        end else if (boundary) begin
            cnt_d    = '0;
            pend_d   = 1'b0;
            active_d = wr_en ? wr_half : next_half;
            // Parking at a boundary must not emit a one-cycle runt high.
            if (active_d == '0) begin
                out_d = 1'b0;
            end else begin
                out_d  = ~out_q;
                tick_d = ~out_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (wr_en) begin
                shadow_d = wr_half;
                pend_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= CNT_W'(DEFAULT_HALF);
            shadow_q <= '0;
            pend_q   <= 1'b0;
            out_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
        end
    end

    assign out_clk = out_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: rtl/clkdiv_multi_ch.sv
// Multi-channel programmable clock/tick generator; decodes the write port and fans out SYNC.
// Latency: write to PENDING is 1 cycle. All outputs are registered. There is no backpressure.
module clkdiv_multi_ch
    import clkdiv_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF,
    parameter int          CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NUM_CH-1:0] EN,
    input  logic              SYNC,
    input  logic              WR_EN,
    input  logic [CH_W-1:0]   WR_CH,
    input  logic [CNT_W-1:0]  WR_HALF,
    output logic [NUM_CH-1:0] OUTCLK,
    output logic [NUM_CH-1:0] TICK,
    output logic [NUM_CH-1:0] PENDING
);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel indices match no channel, so such writes fall away.
        assign wr_sel[i] = WR_EN && (32'(WR_CH) == i);

        clkdiv_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk     (CLK),
            .rst_n   (RST_N),
            .en      (EN[i]),
            .sync    (SYNC),
            .wr_en   (wr_sel[i]),
            .wr_half (WR_HALF),
            .out_clk (OUTCLK[i]),
            .tick    (TICK[i]),
            .pending (PENDING[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi_ch.sv
// Directed bench for clkdiv_multi_ch: 3 channels, 8-bit counters, reset half-period of 4.
module tb_clkdiv_multi_ch;
    import clkdiv_pkg::*;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 2;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [NUM_CH-1:0] EN;
    logic              SYNC;
    logic              WR_EN;
    logic [CH_W-1:0]   WR_CH;
    logic [CNT_W-1:0]  WR_HALF;
    logic [NUM_CH-1:0] OUTCLK;
    logic [NUM_CH-1:0] TICK;
    logic [NUM_CH-1:0] PENDING;

    int n_checks = 0;
    int n_fail   = 0;

    clkdiv_multi_ch #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (4)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .EN      (EN),
        .SYNC    (SYNC),
        .WR_EN   (WR_EN),
        .WR_CH   (WR_CH),
        .WR_HALF (WR_HALF),
        .OUTCLK  (OUTCLK),
        .TICK    (TICK),
        .PENDING (PENDING)
    );

    always #5 CLK = ~CLK;

    // Expected level s cycles after a phase reference, given the first rise cycle and half-period.
    function automatic logic exp_out(input int s, input int first, input int h);
        return (s >= first) && (((s - first) / h) % 2 == 0);
    endfunction

    function automatic logic exp_tick(input int s, input int first, input int h);
        return (s >= first) && ((s - first) % (2 * h) == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int ch, input int half);
        WR_EN   = 1'b1;
        WR_CH   = CH_W'(ch);
        WR_HALF = CNT_W'(half);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; EN = '0; SYNC = 1'b0; WR_EN = 1'b0; WR_CH = '0; WR_HALF = '0;
        repeat (2) step();
        chk("rst_out", OUTCLK, 0);
        chk("rst_tick", TICK, 0);
        chk("rst_pend", PENDING, 0);

        // Release with all channels enabled at the reset half-period of 4.
        EN = 3'b111;
        RST_N = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            step();
            chk("t1_out0", OUTCLK[0], exp_out(s, 4, 4));
            chk("t1_tick0", TICK[0], exp_tick(s, 4, 4));
        end
        chk("t1_all", OUTCLK, 3'b111);

        // ch1 to half 5, aligned by SYNC, then shortened to 3 mid-period.
        wr(1, 5);
        step();
        WR_EN = 1'b0;
        chk("t2_pend_lat", PENDING, 3'b010);
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
        chk("t2_sync_out", OUTCLK, 0);
        chk("t2_sync_pend", PENDING, 0);
        for (int s = 1; s <= 14; s++) begin
            if (s == 3) wr(1, int'(half_from_hz(48, 8)));
            step();
            WR_EN = 1'b0;
            chk("t2_out1", OUTCLK[1], exp_out(s, 5, 3));
            chk("t2_tick1", TICK[1], exp_tick(s, 5, 3));
            chk("t2_pend1", PENDING[1], (s == 3 || s == 4));
        end

        // ch2 parked with half 0, then restarted with half 2.
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
        for (int s = 1; s <= 14; s++) begin
            if (s == 1) wr(2, 0);
            if (s == 7) wr(2, 2);
            step();
            WR_EN = 1'b0;
            chk("t3_out2", OUTCLK[2], exp_out(s, 10, 2));
            chk("t3_tick2", TICK[2], exp_tick(s, 10, 2));
            chk("t3_pend2", PENDING[2], ((s >= 1 && s <= 3) || s == 7));
        end

        // Halves 2,3,5; the ch0 write shares the SYNC cycle and applies at once.
        wr(2, 5);
        step();
        SYNC = 1'b1;
        wr(0, 2);
        step();
        SYNC = 1'b0;
        WR_EN = 1'b0;
        chk("t4_pend_sync", PENDING, 0);
        repeat (7) step();
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
        chk("t4_sync_out", OUTCLK, 0);
        chk("t4_sync_tick", TICK, 0);
        for (int s = 1; s <= 21; s++) begin
            if (s == 7) wr(3, 7);
            step();
            WR_EN = 1'b0;
            chk("t4_out", OUTCLK, {exp_out(s, 5, 5), exp_out(s, 3, 3), exp_out(s, 2, 2)});
            chk("t4_tick", TICK, {exp_tick(s, 5, 5), exp_tick(s, 3, 3), exp_tick(s, 2, 2)});
            if (s == 7) chk("t5_oor_pend", PENDING, 0);
        end

        // Asynchronous reset with a pending write outstanding.
        wr(1, 6);
        step();
        WR_EN = 1'b0;
        chk("t6_pend", PENDING, 3'b010);
        chk("t6_pre_out", OUTCLK, 3'b011);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t6_arst_out", OUTCLK, 0);
        chk("t6_arst_tick", TICK, 0);
        chk("t6_arst_pend", PENDING, 0);
        step();
        RST_N = 1'b1;
        for (int s = 1; s <= 9; s++) begin
            step();
            chk("t6_out", OUTCLK, {3{exp_out(s, 4, 4)}});
            chk("t6_tick", TICK, {3{exp_tick(s, 4, 4)}});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
